// File: rtl/button_bank.sv
// Push-button conditioner bank: per channel synchroniser, sampled debounce,
// press/release pulses and hold-to-repeat, sharing one sample-tick divider.
module button_bank #(
   parameter int N             = 5,
   parameter int SAMPLE_DIV    = 100000,
   parameter int DB_SAMPLES    = 4,
   parameter int REPEAT_DELAY  = 500,
   parameter int REPEAT_PERIOD = 100
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] pb_i,
   input  logic [N-1:0] repeat_en_i,
   output logic [N-1:0] level_o,
   output logic [N-1:0] press_o,
   output logic [N-1:0] release_o,
   output logic [N-1:0] rep_o,
   output logic [N-1:0] evt_o
);
   localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   logic [DW-1:0] div_q, div_d;
   logic          tick;

   assign tick  = (div_q == DW'(SAMPLE_DIV - 1));
   assign div_d = tick ? '0 : div_q + 1'b1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) div_q <= '0;
      else       div_q <= div_d;
   end

   for (genvar i = 0; i < N; i++) begin : g_chan
      button_chan #(
         .DB_SAMPLES    (DB_SAMPLES),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_chan (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .pb_i        (pb_i[i]),
         .tick_i      (tick),
         .repeat_en_i (repeat_en_i[i]),
         .level_o     (level_o[i]),
         .press_o     (press_o[i]),
         .release_o   (release_o[i]),
         .rep_o       (rep_o[i])
      );
   end

   assign evt_o = press_o | rep_o;
endmodule

module button_chan #(
   parameter int DB_SAMPLES    = 4,
   parameter int REPEAT_DELAY  = 500,
   parameter int REPEAT_PERIOD = 100
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pb_i,
   input  logic tick_i,
   input  logic repeat_en_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic rep_o
);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CW   = $clog2(RMAX + 1);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

   logic [1:0]            sync_q;
   logic [DB_SAMPLES-1:0] sr_q, sr_d;
   logic                  level_q, level_d;
   logic                  press_q, press_d;
   logic                  release_q, release_d;
   logic                  rep_q, rep_d;
   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;

   // Level is decided from the post-shift window so it moves on the same edge
   // as the sample that completes the run.
   always_comb begin
      sr_d    = tick_i ? {sr_q[DB_SAMPLES-2:0], sync_q[1]} : sr_q;
      level_d = level_q;
      if (&sr_d)       level_d = 1'b1;
      else if (~|sr_d) level_d = 1'b0;
      press_d   = level_d & ~level_q;
      release_d = ~level_d & level_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rep_d   = 1'b0;
      cnt_inc = cnt_q + 1'b1;
      if (release_d) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: if (press_d) begin
               state_d = HOLD;
               cnt_d   = '0;
            end
            HOLD: begin
               if (!repeat_en_i) cnt_d = '0;
               else if (tick_i) begin
                  if (cnt_inc == CW'(REPEAT_DELAY)) begin
                     rep_d   = 1'b1;
                     cnt_d   = '0;
                     state_d = REPEAT;
                  end else cnt_d = cnt_inc;
               end
            end
            REPEAT: begin
               if (!repeat_en_i) begin
                  state_d = HOLD;
                  cnt_d   = '0;
               end else if (tick_i) begin
                  if (cnt_inc == CW'(REPEAT_PERIOD)) begin
                     rep_d = 1'b1;
                     cnt_d = '0;
                  end else cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q    <= '0;
         sr_q      <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         rep_q     <= 1'b0;
         state_q   <= IDLE;
         cnt_q     <= '0;
      end else begin
         sync_q    <= {sync_q[0], pb_i};
         sr_q      <= sr_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         rep_q     <= rep_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign rep_o     = rep_q;
endmodule

// File: doc/button_bank.md
# button_bank

Parametrised N-channel push-button conditioner for the typing-game board: per channel a 2-FF synchroniser, sampled debounce, and one-cycle press/release pulses, plus hold-to-repeat pulse generation. It sits between the raw BtnC/U/D/L/R pins and `control`. It generalises the per-button debounce/one-pulse pairs into one bank so that held select/volume buttons can auto-step.

## Interface
- `N`, 5: number of button channels.
- `SAMPLE_DIV`, 100000: clk cycles per debounce sample tick (1 ms at 100 MHz); must be ≥1.
- `DB_SAMPLES`, 4: consecutive equal samples needed to change the debounced level; must be ≥2.
- `REPEAT_DELAY`, 500: sample ticks from press to first repeat pulse; must be ≥1.
- `REPEAT_PERIOD`, 100: sample ticks between subsequent repeat pulses; must be ≥1.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, reset is asynchronous and active-high.
- `pb`  in  N  raw asynchronous button inputs, 1 = pressed.
- `repeat_en`  in  N  per-channel auto-repeat enable (synchronous to clk).
- `level`  out  N  debounced button state.
- `press`  out  N  one-cycle pulse on debounced rising edge.
- `release`  out  N  one-cycle pulse on debounced falling edge.
- `rep`  out  N  one-cycle auto-repeat pulse.
- `evt`  out  N  `press | rep`; the step strobe `control` consumes.

## Operation
- Synchroniser: `pb[i]` → two flops → `s[i]`. Reset clears both to 0.
- Tick divider: one shared counter 0..SAMPLE_DIV-1, width `$clog2(SAMPLE_DIV)` (min 1); `tick` is high in the cycle the counter equals SAMPLE_DIV-1, then wraps to 0. SAMPLE_DIV=1 ⇒ tick every cycle.
- Debounce: per channel a DB_SAMPLES-bit shift register loads `s[i]` on tick. Next level = 1 if all ones, 0 if all zeros, else unchanged. `level` is registered; `press[i]` = next level 1 & current level 0, registered on the same edge as `level`, so `press` coincides with the first cycle of `level`=1. `release` symmetric.
- Repeat FSM per channel, states IDLE, HOLD, REPEAT:
  - IDLE: level 0. On press → HOLD, hold counter := 0.
  - HOLD: on each tick with `repeat_en[i]`=1, counter += 1; when it reaches REPEAT_DELAY, pulse `rep`, counter := 0, → REPEAT.
  - REPEAT: on each tick counter += 1; when it reaches REPEAT_PERIOD, pulse `rep`, counter := 0.
  - Any state: release → IDLE, counter := 0, no `rep` in the release cycle.
  - `repeat_en[i]` low in HOLD/REPEAT → HOLD with counter := 0 (repeat restarts from full REPEAT_DELAY when re-enabled).
- Counter width `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)`; no overflow possible.
- Channels fully independent; simultaneous events on different channels all appear in the same cycle.

## Timing
- Reset: all outputs 0, all shift registers 0, FSMs IDLE, divider 0; asynchronous assert, deassert takes effect at the next clk edge.
- Press latency with SAMPLE_DIV=1: `pb` stable high before edge E0 ⇒ `level`/`press` high in the cycle after edge E0+DB_SAMPLES+1. General case: between 2+(DB_SAMPLES-1)·SAMPLE_DIV and 2+DB_SAMPLES·SAMPLE_DIV+1 cycles.
- Glitches shorter than DB_SAMPLES ticks never change `level`.
- `press`, `release`, `rep` each exactly one clk cycle wide; `rep` never coincides with `press` or `release` on the same channel.
- Button held through reset deassertion: treated as a fresh press after debounce latency.
- `evt` is combinational OR of registered `press`/`rep`; no extra latency.

## Test plan
- Defaults overridden: SAMPLE_DIV=1, DB_SAMPLES=3, REPEAT_DELAY=4, REPEAT_PERIOD=2, N=5.
- Clean press ch0: pb[0] rises before edge 10 ⇒ press[0]=1 only in cycle after edge 14, level[0]=1 from then; hold 20 cycles, release ⇒ release[0] single pulse 5 edges after pb falls.
- Bounce: pb[1] toggles 1,0,1,0 each cycle then stable 1 ⇒ exactly one press[1], no release[1].
- Auto-repeat ch2, repeat_en[2]=1: press at edge P ⇒ rep[2] after edges P+4, P+6, P+8…; evt[2] at P, P+4, P+6…; release ⇒ rep stops same cycle.
- repeat_en[2] dropped at P+5, raised at P+9 ⇒ no rep until P+13, then every 2.
- Simultaneous presses ch3 and ch4, SAMPLE_DIV=3 ⇒ press[3] and press[4] in the same cycle; rst pulsed mid-hold ⇒ all outputs 0 immediately, press re-fires after debounce.
